// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LUT neuron: a valid/ready config stream fills a truth-table
// register, which then serves registered single-cycle lookups.
module lut_neuron_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_done,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                busy
);

    localparam int DEPTH  = 2 ** IN_BITS;
    localparam int TBITS  = DEPTH * OUT_BITS;
    localparam int NWORDS = (TBITS + CFG_W - 1) / CFG_W;
    localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    state_t                         state, state_next;
    logic [PTR_W-1:0]               ptr;
    logic [DEPTH-1:0][OUT_BITS-1:0] tbl;
    logic                           accept, last_word, lookup;

    assign accept    = cfg_valid & cfg_ready;
    assign last_word = (ptr == PTR_W'(NWORDS - 1));
    assign lookup    = in_valid & (state == ACTIVE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = LOAD;
            LOAD:    if (cfg_start)                  state_next = LOAD;
                     else if (accept && last_word)   state_next = ACTIVE;
            ACTIVE:  if (cfg_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == LOAD) && !cfg_start;
        busy      = (state == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ptr <= '0;
        else if (cfg_start || (accept && last_word)) ptr <= '0;
        else if (accept)                        ptr <= ptr + 1'b1;
    end

    // NOTE: the table is reset explicitly because reset must invalidate any loaded contents.
    // Padding bits of the final config word map to no table bit and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
        end else if (accept) begin
            for (int i = 0; i < TBITS; i++) begin
                if (ptr == PTR_W'(i / CFG_W))
                    tbl[i / OUT_BITS][i % OUT_BITS] <= cfg_data[i % CFG_W];
            end
        end
    end

    // Lookup reads the table before any same-cycle reload write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            cfg_done  <= accept & last_word;
            out_valid <= lookup;
            if (lookup) out_data <= tbl[in_data];
        end
    end

endmodule
